// File: rtl/systolic_edge_feeder.sv
// Edge feeder for one side (west rows or north columns) of a LANES x LANES
// systolic MAC array. Accepts operand vectors over valid/ready, applies the
// diagonal skew (lane i delayed i steps), flushes with zeros after the tile,
// and generates the array-wide PE enable.
//
//   state    | meaning
//   ---------+----------------------------------------------------------
//   S_IDLE   | waiting for start; skew line holds (all zeros after a tile)
//   S_STREAM | accepting cfg_len vectors; array advances on each accept
//   S_FLUSH  | pushing zeros for 2*(LANES-1)+1 cycles to drain the array
module systolic_edge_feeder #(
    parameter int WIDTH = 16,
    parameter int LANES = 4,
    parameter int CNT_W = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [CNT_W-1:0]       cfg_len,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [LANES*WIDTH-1:0] in_data,
    output logic [LANES*WIDTH-1:0] out_data,
    output logic                   pe_ena,
    output logic                   busy,
    output logic                   done
);

    localparam int FLUSH_LEN = 2 * (LANES - 1) + 1;
    localparam int FLUSH_W   = $clog2(FLUSH_LEN);

    typedef enum logic [1:0] {
        S_IDLE,
        S_STREAM,
        S_FLUSH
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [CNT_W-1:0]     r_len;
    logic [CNT_W-1:0]     w_len_nxt;
    logic [CNT_W-1:0]     r_cnt;
    logic [CNT_W-1:0]     w_cnt_nxt;
    logic [FLUSH_W-1:0]   r_fcnt;
    logic [FLUSH_W-1:0]   w_fcnt_nxt;
    logic                 r_pe_ena;
    logic                 r_busy;
    logic                 r_done;
    logic                 w_busy_nxt;
    logic                 w_done_nxt;
    logic                 w_advance;
    logic [LANES*WIDTH-1:0] w_vec;

    // Handshake and flush shift source depend only on the registered state.
    assign in_ready  = (r_state == S_STREAM);
    assign w_advance = ((r_state == S_STREAM) && in_valid) || (r_state == S_FLUSH);
    assign w_vec     = (r_state == S_FLUSH) ? '0 : in_data;

    // Next-state, counter and registered-output decode.
    always_comb begin
        w_state_nxt = r_state;
        w_len_nxt   = r_len;
        w_cnt_nxt   = r_cnt;
        w_fcnt_nxt  = r_fcnt;
        w_done_nxt  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    if (cfg_len != '0) begin
                        w_len_nxt   = cfg_len;
                        w_cnt_nxt   = '0;
                        w_fcnt_nxt  = '0;
                        w_state_nxt = S_STREAM;
                    end else begin
                        // Empty tile: report completion without touching the array.
                        w_done_nxt = 1'b1;
                    end
                end
            end
            S_STREAM: begin
                if (in_valid) begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                    if (r_cnt == r_len - CNT_W'(1)) begin
                        w_fcnt_nxt  = '0;
                        w_state_nxt = S_FLUSH;
                    end
                end
            end
            S_FLUSH: begin
                if (r_fcnt == FLUSH_W'(FLUSH_LEN - 1)) begin
                    w_done_nxt  = 1'b1;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_fcnt_nxt = r_fcnt + FLUSH_W'(1);
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
        w_busy_nxt = (w_state_nxt != S_IDLE);
    end

    // State, counters and registered status outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_len    <= '0;
            r_cnt    <= '0;
            r_fcnt   <= '0;
            r_pe_ena <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_len    <= w_len_nxt;
            r_cnt    <= w_cnt_nxt;
            r_fcnt   <= w_fcnt_nxt;
            r_pe_ena <= w_advance;
            r_busy   <= w_busy_nxt;
            r_done   <= w_done_nxt;
        end
    end

    assign pe_ena = r_pe_ena;
    assign busy   = r_busy;
    assign done   = r_done;

    // Per-lane skew line: lane i has i delay stages ahead of its output register.
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        logic [WIDTH-1:0] r_out;

        if (gi == 0) begin : g_direct
            // Lane 0 feeds the output register directly.
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    r_out <= '0;
                end else if (w_advance) begin
                    r_out <= w_vec[0 +: WIDTH];
                end
            end
        end else begin : g_delay
            logic [WIDTH-1:0] r_stg [gi];

            // Shift the delay chain and output together so bubbles stall in lockstep.
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    for (int k = 0; k < gi; k++) begin
                        r_stg[k] <= '0;
                    end
                    r_out <= '0;
                end else if (w_advance) begin
                    r_stg[0] <= w_vec[gi*WIDTH +: WIDTH];
                    for (int k = 1; k < gi; k++) begin
                        r_stg[k] <= r_stg[k-1];
                    end
                    r_out <= r_stg[gi-1];
                end
            end
        end

        assign out_data[gi*WIDTH +: WIDTH] = r_out;
    end

endmodule

// File: tb/tb_systolic_edge_feeder.sv
// Self-checking bench for systolic_edge_feeder with a queue-based reference model.
module tb_systolic_edge_feeder;

    localparam int WIDTH = 16;
    localparam int LANES = 4;
    localparam int CNT_W = 8;
    localparam int FLUSH = 2 * (LANES - 1) + 1;

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b0;
    logic                   start = 1'b0;
    logic [CNT_W-1:0]       cfg_len = '0;
    logic                   in_valid = 1'b0;
    logic                   in_ready;
    logic [LANES*WIDTH-1:0] in_data = '0;
    logic [LANES*WIDTH-1:0] out_data;
    logic                   pe_ena;
    logic                   busy;
    logic                   done;

    int n_tests = 0;
    int n_fail  = 0;

    // Tile stimulus and captured observations
    logic [LANES*WIDTH-1:0] vecs[$];
    int                     gaps[$];
    logic [LANES*WIDTH-1:0] pe_q[$];
    int done_cnt, done_idx, hold_err, rdy_err, bub_cnt;
    bit timed_out;

    systolic_edge_feeder #(.WIDTH(WIDTH), .LANES(LANES), .CNT_W(CNT_W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .cfg_len  (cfg_len),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .out_data (out_data),
        .pe_ena   (pe_ena),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    function automatic logic [LANES*WIDTH-1:0] rand_vec();
        logic [LANES*WIDTH-1:0] v;
        for (int i = 0; i < LANES; i++) v[i*WIDTH +: WIDTH] = WIDTH'($urandom);
        return v;
    endfunction

    // Model: on pe_ena cycle p, lane i carries vector (p-i) if it exists, else zero.
    function automatic logic [LANES*WIDTH-1:0] exp_pe(int p);
        logic [LANES*WIDTH-1:0] r;
        logic [LANES*WIDTH-1:0] t;
        r = '0;
        for (int i = 0; i < LANES; i++) begin
            if (p - i >= 0 && p - i < vecs.size()) begin
                t = vecs[p - i];
                r[i*WIDTH +: WIDTH] = t[i*WIDTH +: WIDTH];
            end
        end
        return r;
    endfunction

    // Drives one tile of vecs/gaps and records what the DUT did (no checking here).
    task automatic run_tile(input int k, input bit inject);
        int idx, g, post;
        bit done_seen, injected;
        logic [LANES*WIDTH-1:0] prev;
        pe_q.delete();
        done_cnt = 0; done_idx = -1; hold_err = 0; rdy_err = 0; bub_cnt = 0;
        timed_out = 1'b0; idx = 0; g = 0; post = 0; done_seen = 0; injected = 0;
        @(posedge clk); #1;
        start = 1'b1; cfg_len = CNT_W'(k); in_valid = 1'b0; in_data = rand_vec();
        @(negedge clk);
        prev = out_data;
        for (int cyc = 0; cyc < 400; cyc++) begin
            @(posedge clk); #1;
            start   = 1'b0;
            cfg_len = CNT_W'($urandom);
            if (inject && !injected && idx == 1) begin
                start = 1'b1; cfg_len = 7; injected = 1'b1;
            end
            if (idx < k && g >= gaps[idx]) begin
                in_valid = 1'b1; in_data = vecs[idx];
            end else begin
                in_valid = 1'b0; in_data = rand_vec();
            end
            @(negedge clk);
            if (pe_ena) pe_q.push_back(out_data);
            else if (busy && pe_q.size() > 0) begin
                bub_cnt++;
                if (out_data !== prev) hold_err++;
            end
            prev = out_data;
            if (done) begin done_cnt++; done_idx = pe_q.size(); done_seen = 1'b1; end
            if (idx >= k && in_ready) rdy_err++;
            if (in_valid && in_ready) begin idx++; g = 0; end
            else if (!in_valid) g++;
            if (done_seen) post++;
            if (post >= 4) break;
        end
        if (!done_seen) timed_out = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; start = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int c = 0; c < 2; c++) begin
            @(posedge clk); #1;
            start = 1'($urandom); cfg_len = CNT_W'($urandom);
            in_valid = 1'($urandom); in_data = rand_vec();
            @(negedge clk);
            n_tests++;
            if ({out_data, pe_ena, in_ready, busy, done} !== '0) begin
                n_fail++;
                $display("FAIL reset_outputs: got out=%h pe=%b rdy=%b busy=%b done=%b want all 0",
                         out_data, pe_ena, in_ready, busy, done);
            end
        end
        @(posedge clk); #1;
        rst_n = 1'b1; start = 1'b0; in_valid = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        int lane3_exp [10] = '{0, 0, 0, 4, 8, 12, 0, 0, 0, 0};
        int lane0_exp [10] = '{1, 5, 9, 0, 0, 0, 0, 0, 0, 0};
        logic [LANES*WIDTH-1:0] t;
        vecs.delete(); gaps.delete();
        for (int v = 0; v < 3; v++) begin
            for (int i = 0; i < LANES; i++) t[i*WIDTH +: WIDTH] = WIDTH'(v * LANES + i + 1);
            vecs.push_back(t); gaps.push_back(0);
        end
        run_tile(3, 1'b0);
        n_tests++;
        if (timed_out || pe_q.size() != 10) begin
            n_fail++; $display("FAIL basic_pe_count: got %0d want 10 (timeout=%0b)", pe_q.size(), timed_out);
        end
        n_tests++;
        if (done_cnt != 1 || done_idx != 10) begin
            n_fail++; $display("FAIL basic_done: got count=%0d at pe %0d want 1 at pe 10", done_cnt, done_idx);
        end
        for (int p = 0; p < pe_q.size() && p < 10; p++) begin
            t = pe_q[p];
            n_tests++;
            if (t[3*WIDTH +: WIDTH] !== WIDTH'(lane3_exp[p]) || t[0 +: WIDTH] !== WIDTH'(lane0_exp[p])) begin
                n_fail++;
                $display("FAIL basic_lane03 pe%0d: got l0=%0d l3=%0d want l0=%0d l3=%0d",
                         p, t[0 +: WIDTH], t[3*WIDTH +: WIDTH], lane0_exp[p], lane3_exp[p]);
            end
            n_tests++;
            if (t !== exp_pe(p)) begin
                n_fail++; $display("FAIL basic_vec pe%0d: got %h want %h", p, t, exp_pe(p));
            end
        end
        n_tests++;
        if (rdy_err != 0 || bub_cnt != 0) begin
            n_fail++; $display("FAIL basic_ready_bubble: got rdy_err=%0d bubbles=%0d want 0 0", rdy_err, bub_cnt);
        end
    endtask

    task automatic test_bubble();
        gaps.delete();
        gaps.push_back(0); gaps.push_back(2); gaps.push_back(0);
        run_tile(3, 1'b0);
        n_tests++;
        if (timed_out || pe_q.size() != 10 || done_idx != 10 || done_cnt != 1) begin
            n_fail++; $display("FAIL bubble_count: got pe=%0d done@%0d x%0d want 10 10 1", pe_q.size(), done_idx, done_cnt);
        end
        n_tests++;
        if (bub_cnt != 2 || hold_err != 0) begin
            n_fail++; $display("FAIL bubble_hold: got stalls=%0d hold_err=%0d want 2 0", bub_cnt, hold_err);
        end
        for (int p = 0; p < pe_q.size() && p < 10; p++) begin
            n_tests++;
            if (pe_q[p] !== exp_pe(p)) begin
                n_fail++; $display("FAIL bubble_vec pe%0d: got %h want %h", p, pe_q[p], exp_pe(p));
            end
        end
    endtask

    task automatic test_zero_len();
        int dcount = 0, bad = 0;
        @(posedge clk); #1;
        start = 1'b1; cfg_len = '0; in_valid = 1'b1; in_data = rand_vec();
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            start = 1'b0;
            @(negedge clk);
            if (done) dcount++;
            if (pe_ena || in_ready || busy) bad++;
            if (c == 0) begin
                n_tests++;
                if (done !== 1'b1) begin
                    n_fail++; $display("FAIL zero_len_done: got %b want 1 one cycle after start", done);
                end
            end
        end
        n_tests++;
        if (dcount != 1 || bad != 0) begin
            n_fail++; $display("FAIL zero_len_quiet: got done_cycles=%0d active_cycles=%0d want 1 0", dcount, bad);
        end
        in_valid = 1'b0;
    endtask

    task automatic test_start_ignored();
        vecs.delete(); gaps.delete();
        for (int v = 0; v < 3; v++) begin vecs.push_back(rand_vec()); gaps.push_back(0); end
        run_tile(3, 1'b1);
        n_tests++;
        if (timed_out || pe_q.size() != 3 + FLUSH || done_idx != 3 + FLUSH || done_cnt != 1) begin
            n_fail++; $display("FAIL start_ignored: got pe=%0d done@%0d x%0d timeout=%0b want %0d", pe_q.size(),
                               done_idx, done_cnt, timed_out, 3 + FLUSH);
        end
        for (int p = 0; p < pe_q.size(); p++) begin
            n_tests++;
            if (pe_q[p] !== exp_pe(p)) begin
                n_fail++; $display("FAIL start_ignored_vec pe%0d: got %h want %h", p, pe_q[p], exp_pe(p));
            end
        end
    endtask

    task automatic test_reset_mid_flush();
        int idx = 0, fc = 0, cnt, pos;
        logic [LANES*WIDTH-1:0] t;
        vecs.delete(); gaps.delete();
        for (int v = 0; v < 3; v++) begin vecs.push_back(rand_vec()); gaps.push_back(0); end
        @(posedge clk); #1;
        start = 1'b1; cfg_len = 3;
        for (int c = 0; c < 50 && fc < 2; c++) begin
            @(posedge clk); #1;
            start = 1'b0;
            in_valid = (idx < 3);
            in_data  = (idx < 3) ? vecs[idx] : rand_vec();
            @(negedge clk);
            if (in_valid && in_ready) idx++;
            else if (idx == 3 && busy && !in_ready) fc++;
        end
        n_tests++;
        if (fc < 2) begin
            n_fail++; $display("FAIL midflush_reach: got flush_cycles=%0d want 2", fc);
        end
        @(posedge clk); #1;
        rst_n = 1'b0; in_valid = 1'b0;
        @(posedge clk); #1;
        n_tests++;
        if ({out_data, pe_ena, in_ready, busy, done} !== '0) begin
            n_fail++; $display("FAIL midflush_reset: got out=%h pe=%b rdy=%b busy=%b done=%b want all 0",
                               out_data, pe_ena, in_ready, busy, done);
        end
        rst_n = 1'b1;
        vecs.delete(); gaps.delete();
        vecs.push_back({LANES{16'hFFFF}}); gaps.push_back(0);
        run_tile(1, 1'b0);
        n_tests++;
        if (timed_out || pe_q.size() != 1 + FLUSH) begin
            n_fail++; $display("FAIL midflush_tile_len: got %0d want %0d", pe_q.size(), 1 + FLUSH);
        end
        for (int i = 0; i < LANES; i++) begin
            cnt = 0; pos = -1;
            for (int p = 0; p < pe_q.size(); p++) begin
                t = pe_q[p];
                if (t[i*WIDTH +: WIDTH] == 16'hFFFF) begin cnt++; pos = p + 1; end
            end
            n_tests++;
            if (cnt != 1 || pos != i + 1) begin
                n_fail++; $display("FAIL midflush_lane%0d: got count=%0d pos=%0d want 1 at %0d", i, cnt, pos, i + 1);
            end
        end
    endtask

    task automatic test_random();
        int k;
        for (int tile = 0; tile < 6; tile++) begin
            k = $urandom_range(1, 12);
            vecs.delete(); gaps.delete();
            for (int v = 0; v < k; v++) begin
                vecs.push_back(rand_vec());
                gaps.push_back(($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 3));
            end
            run_tile(k, 1'b0);
            n_tests++;
            if (timed_out || pe_q.size() != k + FLUSH || done_idx != k + FLUSH || done_cnt != 1) begin
                n_fail++; $display("FAIL rand%0d_count: got pe=%0d done@%0d x%0d want %0d", tile, pe_q.size(),
                                   done_idx, done_cnt, k + FLUSH);
            end
            n_tests++;
            if (hold_err != 0 || rdy_err != 0) begin
                n_fail++; $display("FAIL rand%0d_hold_ready: got hold_err=%0d rdy_err=%0d want 0 0", tile, hold_err, rdy_err);
            end
            for (int p = 0; p < pe_q.size(); p++) begin
                n_tests++;
                if (pe_q[p] !== exp_pe(p)) begin
                    n_fail++; $display("FAIL rand%0d_vec pe%0d: got %h want %h", tile, p, pe_q[p], exp_pe(p));
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_bubble();
        test_zero_len();
        test_start_ignored();
        test_reset_mid_flush();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got no completion want finish before 500000");
        $fatal(1);
    end

endmodule
